// File: rtl/noc_harness_pkg.sv
// noc_harness_pkg: shared types and helpers for the NoC traffic harness.
//   packet_t        - network packet; the harness owns its data field
//   harness_pkt_t   - {src, dest, seq, payload} view of packet_t.data
//   harness_state_e - run-control FSM states
//   lfsr_next       - 16-bit Galois LFSR step, x^16+x^14+x^13+x^11+1
package noc_harness_pkg;

    localparam int unsigned NODE_ID_W   = 8;
    localparam int unsigned SEQ_FIELD_W = 16;
    localparam int unsigned PAYLOAD_W   = 16;
    localparam int unsigned PKT_DATA_W  = 2 * NODE_ID_W + SEQ_FIELD_W + PAYLOAD_W;
    localparam int unsigned CSUM_W      = NODE_ID_W + SEQ_FIELD_W + PAYLOAD_W;

    // Right-shifting Galois form; the mask holds taps 16, 14, 13 and 11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [PKT_DATA_W-1:0] data;
    } packet_t;

    typedef struct packed {
        logic [NODE_ID_W-1:0]   src;
        logic [NODE_ID_W-1:0]   dest;
        logic [SEQ_FIELD_W-1:0] seq;
        logic [PAYLOAD_W-1:0]   payload;
    } harness_pkt_t;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        ERROR
    } harness_state_e;

    function automatic packet_t pack_pkt(input harness_pkt_t h);
        packet_t p;
        p.data = h;
        return p;
    endfunction

    function automatic harness_pkt_t unpack_pkt(input packet_t p);
        return harness_pkt_t'(p.data);
    endfunction

    // Checksum key deliberately excludes dest so a misrouted packet is
    // reported by err_cnt rather than as a checksum mismatch.
    function automatic logic [CSUM_W-1:0] csum_key(input harness_pkt_t h);
        return {h.src, h.seq, h.payload};
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/noc_traffic_harness_injector.sv
// noc_node_injector: per-node packet source.
//   clk, reset - clock, synchronous active-high reset
//   clear      - reseed and zero counters at the start of a run
//   run        - high while the harness is in RUN
//   en         - network back-pressure; transfer when data_val && en
//   data       - packet offered to the network
//   data_val   - packet valid (held until accepted)
//   done       - PKTS_PER_NODE packets accepted this run
//   accept     - transfer happening this cycle
module noc_node_injector
    import noc_harness_pkg::*;
#(
    parameter int unsigned NODES         = 4,
    parameter int unsigned NODE_IDX      = 0,
    parameter int unsigned PKTS_PER_NODE = 256,
    parameter int unsigned RATE          = 128,
    parameter int unsigned SEQ_W         = 16
)(
    input  logic    clk,
    input  logic    reset,
    input  logic    clear,
    input  logic    run,
    input  logic    en,
    output packet_t data,
    output logic    data_val,
    output logic    done,
    output logic    accept
);

    logic [15:0]      lfsr;
    logic [31:0]      acc_cnt;
    logic [31:0]      acc_next;
    logic [SEQ_W-1:0] seq_cnt;
    logic [SEQ_W-1:0] seq_next;
    logic             free;
    logic             offer;
    logic [31:0]      dest_raw;
    logic [31:0]      dest_sel;
    harness_pkt_t     pkt;

    assign accept   = data_val && en;
    assign done     = (acc_cnt == PKTS_PER_NODE);
    assign acc_next = acc_cnt + 32'(accept);
    assign seq_next = seq_cnt + SEQ_W'(accept);

    // A slot is free when nothing is pending or the pending packet leaves
    // this cycle, which lets a new packet follow back-to-back.
    assign free  = !data_val || accept;
    assign offer = run && free && (acc_next < PKTS_PER_NODE) && (32'(lfsr[7:0]) < RATE);

    assign dest_raw = 32'(lfsr[15:8]) % NODES;
    assign dest_sel = (dest_raw == NODE_IDX) ? ((NODE_IDX + 1) % NODES) : dest_raw;

    always_comb begin
        pkt         = '0;
        pkt.src     = NODE_ID_W'(NODE_IDX);
        pkt.dest    = NODE_ID_W'(dest_sel);
        pkt.seq     = SEQ_FIELD_W'(seq_next);
        pkt.payload = lfsr;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lfsr     <= 16'(NODE_IDX + 1);
            acc_cnt  <= '0;
            seq_cnt  <= '0;
            data     <= '0;
            data_val <= 1'b0;
        end else begin
            acc_cnt <= acc_next;
            seq_cnt <= seq_next;
            if (run && free) begin
                lfsr <= lfsr_next(lfsr);
            end
            if (offer) begin
                data     <= pack_pkt(pkt);
                data_val <= 1'b1;
            end else if (accept) begin
                data_val <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/noc_traffic_harness.sv
// noc_traffic_harness: self-test traffic generator/checker for the NoC.
//   clk, reset - clock, synchronous active-high reset
//   start      - level; begins/re-arms a run from IDLE, DONE or ERROR
//   o_data, o_data_val, i_en - injection side (to network inputs)
//   i_data, i_data_val       - ejection side (from network outputs)
//   led        - [0] heartbeat, [1] running, [2] pass, [3] error
//   sent_cnt, recv_cnt, err_cnt - run statistics
module noc_traffic_harness
    import noc_harness_pkg::*;
#(
    parameter int unsigned NODES         = 4,
    parameter int unsigned PKTS_PER_NODE = 256,
    parameter int unsigned RATE          = 128,
    parameter int unsigned SEQ_W         = 16,
    parameter int unsigned DRAIN_TIMEOUT = 65535,
    parameter int unsigned HB_BITS       = 24
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output packet_t          o_data     [0:NODES-1],
    output logic [0:NODES-1] o_data_val,
    input  logic [0:NODES-1] i_en,
    input  packet_t          i_data     [0:NODES-1],
    input  logic [0:NODES-1] i_data_val,
    output logic [3:0]       led,
    output logic [31:0]      sent_cnt,
    output logic [31:0]      recv_cnt,
    output logic [15:0]      err_cnt
);

    harness_state_e     state;
    logic [0:NODES-1]   node_done;
    logic [0:NODES-1]   accept;
    logic [0:NODES-1]   bad_rx;
    logic [CSUM_W-1:0]  sent_csum;
    logic [CSUM_W-1:0]  recv_csum;
    logic [CSUM_W-1:0]  sent_fold;
    logic [CSUM_W-1:0]  recv_fold;
    logic [31:0]        sent_inc;
    logic [31:0]        recv_inc;
    logic [31:0]        err_sum;
    logic [31:0]        drain_timer;
    logic [HB_BITS-1:0] hb_cnt;
    logic               hb_led;
    logic [2:0]         status_led;
    logic               parked;
    logic               run;
    harness_pkt_t       rx_pkt;

    assign run    = (state == RUN);
    assign parked = (state == IDLE) || (state == DONE) || (state == ERROR);
    assign led    = {status_led, hb_led};

    for (genvar n = 0; n < NODES; n++) begin : g_node
        noc_node_injector #(
            .NODES        (NODES),
            .NODE_IDX     (n),
            .PKTS_PER_NODE(PKTS_PER_NODE),
            .RATE         (RATE),
            .SEQ_W        (SEQ_W)
        ) u_injector (
            .clk     (clk),
            .reset   (reset),
            .clear   (start && parked),
            .run     (run),
            .en      (i_en[n]),
            .data    (o_data[n]),
            .data_val(o_data_val[n]),
            .done    (node_done[n]),
            .accept  (accept[n])
        );
    end

    // Ejections are accepted unconditionally; anything arriving while no
    // run is active is a stray and counts as an error.
    always_comb begin
        sent_fold = '0;
        recv_fold = '0;
        bad_rx    = '0;
        rx_pkt    = '0;
        for (int unsigned n = 0; n < NODES; n++) begin
            if (accept[n]) begin
                sent_fold = sent_fold ^ csum_key(unpack_pkt(o_data[n]));
            end
            if (i_data_val[n]) begin
                rx_pkt    = unpack_pkt(i_data[n]);
                recv_fold = recv_fold ^ csum_key(rx_pkt);
                bad_rx[n] = parked || (rx_pkt.dest != NODE_ID_W'(n));
            end
        end
    end

    assign sent_inc = 32'($countones(accept));
    assign recv_inc = 32'($countones(i_data_val));
    assign err_sum  = 32'(err_cnt) + 32'($countones(bad_rx));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sent_cnt    <= '0;
            recv_cnt    <= '0;
            err_cnt     <= '0;
            sent_csum   <= '0;
            recv_csum   <= '0;
            drain_timer <= '0;
            status_led  <= '0;
        end else begin
            sent_cnt  <= sent_cnt + sent_inc;
            recv_cnt  <= recv_cnt + recv_inc;
            err_cnt   <= (err_sum > 32'h0000_FFFF) ? '1 : err_sum[15:0];
            sent_csum <= sent_csum ^ sent_fold;
            recv_csum <= recv_csum ^ recv_fold;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state      <= RUN;
                        status_led <= 3'b001;
                        sent_cnt   <= '0;
                        recv_cnt   <= '0;
                        err_cnt    <= '0;
                        sent_csum  <= '0;
                        recv_csum  <= '0;
                    end
                end
                RUN: begin
                    if (&node_done) begin
                        state       <= DRAIN;
                        drain_timer <= '0;
                    end
                end
                DRAIN: begin
                    if (recv_cnt == sent_cnt) begin
                        if ((recv_csum == sent_csum) && (err_cnt == '0)) begin
                            state      <= DONE;
                            status_led <= 3'b010;
                        end else begin
                            state      <= ERROR;
                            status_led <= 3'b100;
                        end
                    end else if (drain_timer == DRAIN_TIMEOUT) begin
                        state      <= ERROR;
                        status_led <= 3'b100;
                    end else begin
                        drain_timer <= drain_timer + 32'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    status_led <= '0;
                end
            endcase
        end
    end

    // Heartbeat flips each time the free-running counter wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            hb_cnt <= '0;
            hb_led <= 1'b0;
        end else begin
            hb_cnt <= hb_cnt + HB_BITS'(1);
            if (&hb_cnt) begin
                hb_led <= ~hb_led;
            end
        end
    end

endmodule
